// File: rtl/recip_calc.sv
// recip_calc: sequential fixed-point reciprocal, recip = 2^Q / steps,
// computed by restoring division with one quotient bit per clock.
// Ports: clk, rst_n (async, active-low), start, steps[N-1:0] in;
//        busy, done (1-cycle pulse), div_zero, recip[N-1:0] out.
// Optional: define RECIP_ROUND_EN for round-half-up of the result.
module recip_calc #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] steps,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] recip
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0] ONE_Q = N'(1) << Q;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_divisor;
    logic [N-1:0]  r_dividend;
    logic [N-1:0]  r_quot;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_zero;

    logic [N:0]    w_rem_sh;
    logic          w_ge;
    logic [N:0]    w_rem_nx;
    logic [N-1:0]  w_quot_nx;
    logic [N-1:0]  w_result;

    // The remainder is always below the divisor, so its top bit is
    // zero and the shift can drop it without losing information.
    assign w_rem_sh  = {r_rem[N-1:0], r_dividend[N-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
    assign w_quot_nx = {r_quot[N-2:0], w_ge};

`ifdef RECIP_ROUND_EN
    logic          w_rnd;
    logic [N-1:0]  w_quot_inc;

    // Half-up: compare twice the final remainder against the divisor.
    assign w_rnd      = ({w_rem_nx, 1'b0} >= {2'b00, r_divisor});
    assign w_quot_inc = w_quot_nx + N'(1);
    // An all-ones quotient stays saturated instead of wrapping.
    assign w_result   = (w_rnd && !(&w_quot_nx)) ? w_quot_inc : w_quot_nx;
`else
    assign w_result   = w_quot_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            recip      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_divisor  <= steps;
                        r_dividend <= ONE_Q;
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        div_zero   <= 1'b0;
                        busy       <= 1'b1;
                        if (steps != '0) begin
                            r_state <= DIV;
                        end else begin
                            r_zero  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                DIV: begin
                    r_rem      <= w_rem_nx;
                    r_quot     <= w_quot_nx;
                    r_dividend <= {r_dividend[N-2:0], 1'b0};
                    r_cnt      <= r_cnt + CW'(1);
                    // The last step publishes the result directly so
                    // done rises on the edge that enters FIN.
                    if (r_cnt == CNT_LAST) begin
                        recip   <= w_result;
                        done    <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    if (r_zero) begin
                        // Zero divisor: publish saturated result here.
                        r_zero   <= 1'b0;
                        recip    <= '1;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recip_calc.sv
// tb_recip_calc: directed self-checking bench for recip_calc.
// Hand-computed 2^16/steps vectors, latency, pulse and reset checks.
module tb_recip_calc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] steps;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] recip;

    int n_assert;
    int n_fail;

    recip_calc #(
        .N(32),
        .Q(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .steps    (steps),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .recip    (recip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] s,
                       input logic [31:0] er, input logic ez,
                       input int elat);
        int lat;
        @(negedge clk);
        steps = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        steps = $urandom;
        chk({tag, "_busy_e0"}, {31'b0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_recip"}, recip, er);
        chk({tag, "_divzero"}, {31'b0, div_zero}, {31'b0, ez});
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        chk({tag, "_recip_hold"}, recip, er);
    endtask

    int          ndone;
    logic [31:0] cap;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        steps    = '0;
        #23;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_divzero", {31'b0, div_zero}, 32'd0);
        chk("rst_recip", recip, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("s1", 32'd1, 32'h0001_0000, 1'b0, 33);
        run("s4", 32'd4, 32'h0000_4000, 1'b0, 33);
        run("s65536", 32'd65536, 32'h0000_0001, 1'b0, 33);
`ifdef RECIP_ROUND_EN
        run("s6", 32'd6, 32'h0000_2AAB, 1'b0, 33);
`else
        run("s6", 32'd6, 32'h0000_2AAA, 1'b0, 33);
`endif
        run("smax", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
        run("s0", 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        run("s2", 32'd2, 32'h0000_8000, 1'b0, 33);
        run("s5", 32'd5, 32'h0000_3333, 1'b0, 33);

        // Second start while busy must be ignored.
        @(negedge clk);
        steps = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        cap   = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1;
                steps = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                cap = recip;
            end
        end
        chk("ign_ndone", ndone, 32'd1);
        chk("ign_recip", cap, 32'h0000_5555);

        // Asynchronous reset mid-computation.
        @(negedge clk);
        steps = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_divzero", {31'b0, div_zero}, 32'd0);
        chk("arst_recip", recip, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 32'd0);
        run("s7", 32'd7, 32'h0000_2492, 1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
